// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg
// Shared definitions for the ROM read sequencer: default geometry,
// the FSM state encoding and a helper that turns an address width into
// a memory depth.
package rom_seq_pkg;

    localparam int DEF_MEM_ADDR_SIZE = 3;
    localparam int DEF_DATA_WIDTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/rom_seq_reader_if.sv
// rom_seq_reader_if
// Bundles the request, ROM and stream signals of the read sequencer.
//   request : start, start_addr, len -> busy, done, err
//   ROM     : rom_en, rom_addr -> ROM, rom_data <- ROM
//   stream  : out_data, out_valid -> consumer, out_ready <- consumer
// Modports:
//   master : the sequencer's view
//   slave  : the surrounding system's view (requester, ROM, consumer)
interface rom_seq_reader_if import rom_seq_pkg::*; #(
    parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) ();

    logic                     start;
    logic [MEM_ADDR_SIZE-1:0] start_addr;
    logic [MEM_ADDR_SIZE:0]   len;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic                     rom_en;
    logic [MEM_ADDR_SIZE-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]    rom_data;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  start, start_addr, len, rom_data, out_ready,
        output busy, done, err, rom_en, rom_addr, out_data, out_valid
    );

    modport slave (
        output start, start_addr, len, rom_data, out_ready,
        input  busy, done, err, rom_en, rom_addr, out_data, out_valid
    );

endinterface

// File: rtl/rom_seq_fifo2.sv
// rom_seq_fifo2
// Two-entry register buffer placed behind the ROM's registered output.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data this cycle
//   push_data : word to write
//   pop       : consume the head entry (caller guarantees count != 0)
//   count     : number of stored entries, 0..2
//   head      : oldest entry, held steady until popped
// The caller never pushes into a full buffer; its issue credit makes that
// impossible, so no overflow handling is needed here.
module rom_seq_fifo2 import rom_seq_pkg::*; #(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       cnt;

    // entry0 is always the head; entry1 only holds the second word.
    // On a simultaneous push and pop the new word lands wherever the
    // head will be after the shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = cnt;
    assign head  = entry0;

endmodule

// File: rtl/rom_seq_reader.sv
// rom_seq_reader
// Burst read sequencer in front of a single-port ROM with one cycle of
// read latency. A request (start_addr, len) is turned into one ROM read per
// cycle; returned words go through a 2-entry buffer onto a valid/ready
// stream. Reads are only issued while the buffer plus the word in flight
// leaves room, so backpressure never drops data.
// Ports:
//   clk, rst : clock shared with the ROM, synchronous active-high reset
//   bus      : rom_seq_reader_if.master (request, ROM and stream signals)
// Configuration macro:
//   ROM_SEQ_WRAP_EN : when defined, a burst may run past the top address and
//                     wrap to 0; otherwise start_addr+len > DEPTH is rejected.
module rom_seq_reader import rom_seq_pkg::*; #(
    parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    rom_seq_reader_if.master  bus
);

    localparam int AW    = MEM_ADDR_SIZE;
    localparam int DEPTH = depth_of(MEM_ADDR_SIZE);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;

    logic [1:0]            state;
    logic [AW:0]           remaining;
    logic [AW-1:0]         addr_cnt;
    logic                  in_flight;
    logic                  done_pulse;
    logic                  err_pulse;
    logic [1:0]            fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  pop;
    logic                  issue;
    logic                  last_pop;
    logic                  req_bad;
    logic [2:0]            credit_used;
    logic [AW+1:0]         len_ext;

    assign pop = (fifo_count != 2'd0) && bus.out_ready;

    // Slots already claimed: stored words plus the word the ROM is returning,
    // minus the one leaving this cycle. A new read needs a free slot.
    assign credit_used = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
    assign issue       = (state == S_RUN) && (remaining != '0) && (credit_used < 3'd2);

    // In DRAIN every read has issued, so the burst ends when the only word
    // left (nothing in flight, one stored) is handed over.
    assign last_pop = (state == S_DRAIN) && pop && !in_flight && (fifo_count == 2'd1);

    assign len_ext = {1'b0, bus.len};

`ifdef ROM_SEQ_WRAP_EN
    assign req_bad = (len_ext > DEPTH_W);
`else
    logic [AW+1:0] end_ext;
    assign end_ext = {2'b00, bus.start_addr} + len_ext;
    assign req_bad = (len_ext > DEPTH_W) || (end_ext > DEPTH_W);
`endif

    // Control FSM. Request inputs are looked at only in IDLE, which also
    // makes start a no-op while busy. The in-flight flag mirrors the
    // previous cycle's rom_en so only genuine ROM outputs are captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= '0;
            addr_cnt   <= '0;
            in_flight  <= 1'b0;
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            in_flight  <= issue;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (req_bad) begin
                            err_pulse <= 1'b1;
                        end else if (bus.len == '0) begin
                            done_pulse <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            remaining <= bus.len;
                            addr_cnt  <= bus.start_addr;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        remaining <= remaining - 1'b1;
                        addr_cnt  <= addr_cnt + 1'b1;
                        if (remaining == {{AW{1'b0}}, 1'b1}) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (last_pop) begin
                        state      <= S_IDLE;
                        done_pulse <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rom_seq_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_flight),
        .push_data (bus.rom_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_pulse;
    assign bus.err       = err_pulse;
    assign bus.rom_en    = issue;
    assign bus.rom_addr  = addr_cnt;
    assign bus.out_data  = fifo_head;
    assign bus.out_valid = (fifo_count != 2'd0);

endmodule

// File: tb/tb_rom_seq_reader.sv
// tb_rom_seq_reader
// Scoreboard bench for rom_seq_reader. Requests are issued by the main
// process, which pushes the expected ROM addresses, stream words and
// done/err pulses; a negedge monitor compares them against the DUT.
// A behavioural ROM (registered output, junk while disabled) sits on the bus.
// Honours ROM_SEQ_WRAP_EN the same way as the design.
module tb_rom_seq_reader;
    import rom_seq_pkg::*;

    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rom_seq_reader_if #(.MEM_ADDR_SIZE(AW), .DATA_WIDTH(DW)) bus ();

    rom_seq_reader #(.MEM_ADDR_SIZE(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM model: one cycle latency, random junk when not enabled
    logic [DW-1:0] rom_mem [DEPTH];
    logic [DW-1:0] rom_q = '0;
    initial rom_mem = '{4'h0, 4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF};
    always @(posedge clk) rom_q <= bus.rom_en ? rom_mem[bus.rom_addr] : DW'($urandom);
    assign bus.rom_data = rom_q;

    // scoreboard state
    logic [DW-1:0] data_q[$];
    int            addr_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  done_due = 0;
    bit  err_due = 0;
    bit  burst_active = 0;
    int  burst_left = 0;
    int  outstanding = 0;
    bit  ready_rand = 0;
    logic ready_force = 1'b1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic fail_note(input string name, input int actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%0d expected=none", name, actual);
    endtask

    task automatic flush_model();
        data_q.delete();
        addr_q.delete();
        burst_left   = 0;
        burst_active = 0;
        done_due     = 0;
        err_due      = 0;
        outstanding  = 0;
    endtask

    // Issues one request (caller guarantees the DUT is idle) and records
    // what the reference model says must follow.
    task automatic apply_stimulus(input int a, input int l);
        bit reject;
        bus.start      = 1'b1;
        bus.start_addr = AW'(a);
        bus.len        = (AW+1)'(l);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        reject = (l > DEPTH);
`ifndef ROM_SEQ_WRAP_EN
        if (a + l > DEPTH) reject = 1;
`endif
        if (reject) begin
            err_due = 1;
        end else if (l == 0) begin
            done_due = 1;
        end else begin
            burst_active = 1;
            burst_left   = l;
            for (int i = 0; i < l; i++) begin
                addr_q.push_back((a + i) % DEPTH);
                data_q.push_back(rom_mem[(a + i) % DEPTH]);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((bus.busy || burst_active) && n < 400);
        if (n >= 400) fail_note("idle_timeout", n);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"},      bus.busy,      0);
        check_output({tag, "_done"},      bus.done,      0);
        check_output({tag, "_err"},       bus.err,       0);
        check_output({tag, "_rom_en"},    bus.rom_en,    0);
        check_output({tag, "_out_valid"}, bus.out_valid, 0);
        check_output({tag, "_rom_addr"},  bus.rom_addr,  0);
        check_output({tag, "_out_data"},  bus.out_data,  0);
    endtask

    // out_ready driver, updated early in every cycle
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // monitor: compares pulses, busy, issued addresses and stream words
    always @(negedge clk) begin
        if (!rst) begin
            check_output("done_pulse", bus.done, done_due);
            check_output("err_pulse",  bus.err,  err_due);
            check_output("busy",       bus.busy, burst_active);
            done_due = 0;
            err_due  = 0;
            if (bus.rom_en) begin
                if (addr_q.size() == 0) fail_note("spurious_rom_en", bus.rom_addr);
                else check_output("rom_addr", bus.rom_addr, addr_q.pop_front());
                outstanding++;
            end
            if (bus.out_valid) begin
                if (data_q.size() == 0) begin
                    fail_note("spurious_out_valid", bus.out_data);
                end else begin
                    check_output("out_data", bus.out_data, data_q[0]);
                    if (bus.out_ready) begin
                        void'(data_q.pop_front());
                        outstanding--;
                        burst_left--;
                        if (burst_left == 0) begin
                            done_due     = 1;
                            burst_active = 0;
                        end
                    end
                end
            end
            check_output("outstanding_le2", int'(outstanding <= 2), 1);
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;

        // reset state
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic burst with latency checks
        $display("[TB] basic burst");
        apply_stimulus(2, 3);
        @(negedge clk);
        check_output("lat_t1_rom_en",    bus.rom_en,    1);
        check_output("lat_t1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check_output("lat_t2_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check_output("lat_t3_out_valid", bus.out_valid, 1);
        check_output("lat_t3_out_data",  bus.out_data,  1);
        wait_idle();

        // backpressure: six stalled cycles, then an ignored start while busy
        $display("[TB] backpressure");
        ready_force = 1'b0;
        apply_stimulus(0, 8);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_output("stall_rom_en", bus.rom_en, (i <= 2) ? 1 : 0);
            if (i >= 3) begin
                check_output("stall_out_valid", bus.out_valid, 1);
                check_output("stall_out_data",  bus.out_data,  0);
            end
        end
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = 3'd5;
        bus.len        = 4'd2;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        // edge requests
        $display("[TB] edge requests");
        apply_stimulus(5, 0);
        wait_idle();
        apply_stimulus(0, 9);
        wait_idle();
        apply_stimulus(6, 3);
        wait_idle();

        // reset in the middle of a burst
        $display("[TB] reset mid-burst");
        apply_stimulus(0, 8);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush_model();
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        apply_stimulus(3, 1);
        wait_idle();

        // reset and start together: reset wins
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 3'd0;
        bus.len        = 4'd3;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        flush_model();
        @(negedge clk);
        check_output("rst_start_busy",   bus.busy,   0);
        check_output("rst_start_rom_en", bus.rom_en, 0);
        @(posedge clk);
        #1;

        // randomized bursts with random backpressure
        $display("[TB] random bursts");
        ready_rand = 1;
        for (int n = 0; n < 40; n++) begin
            int a;
            int l;
            int pick;
            a    = $urandom_range(0, DEPTH - 1);
            pick = $urandom_range(0, 9);
            if (pick == 0)      l = 0;
            else if (pick == 1) l = DEPTH + 1;
            else                l = $urandom_range(1, DEPTH);
            apply_stimulus(a, l);
            wait_idle();
        end
        ready_rand  = 0;
        ready_force = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        check_output("final_addr_q_empty", addr_q.size(), 0);
        check_output("final_data_q_empty", data_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
